// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control FSM.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDI_EX = 4'd10,
    S_ADDI_WB = 4'd11,
    S_HALT    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_SEXT    = 2'b10;
  localparam logic [1:0] SRCB_SEXT_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that talk to the memory port and therefore may stall on mem_ready.
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mips_mem_wait_timer.sv
// Saturating wait counter for memory stalls; flags a timeout on the wait
// cycle that would bring the number of consecutive stalls to MAX_WAIT.
module mips_mem_wait_timer #(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_timeout
);

  localparam logic [WAIT_W-1:0] LIMIT   = WAIT_W'(MAX_WAIT - 1);
  localparam logic [WAIT_W-1:0] CNT_MAX = '1;

  logic [WAIT_W-1:0] r_cnt;

  // Count stalled cycles; restart on every state change, never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // The current stalled cycle is the MAX_WAIT-th one when LIMIT are already counted.
  assign o_timeout = i_inc && (r_cnt >= LIMIT);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences PC, regfile, ALU and the unified
// memory port one step per cycle, stalling on mem_ready.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 8
) (
  input  logic       clock,
  input  logic       Reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_write_cond_ne,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] aluop,
  output logic [1:0] pcsource,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       bus_error
);

  state_t r_state;
  state_t w_next;
  logic   w_timeout;
  logic   w_inc;
  logic   w_clr;
  logic   w_set_illegal;
  logic   r_illegal;
  logic   r_bus_error;

  assign w_inc = is_mem_state(r_state) && !mem_ready;
  assign w_clr = (w_next != r_state);

  mips_mem_wait_timer #(
    .MAX_WAIT (MAX_WAIT),
    .WAIT_W   (WAIT_W)
  ) u_wait_timer (
    .clk       (clock),
    .rst_n     (Reset),
    .i_clr     (w_clr),
    .i_inc     (w_inc),
    .o_timeout (w_timeout)
  );

  // State register.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      r_illegal   <= 1'b0;
      r_bus_error <= 1'b0;
    end else begin
      if (w_set_illegal) r_illegal   <= 1'b1;
      if (w_timeout)     r_bus_error <= 1'b1;
    end
  end

  // Next-state and control decode; FETCH/MEMWR handshakes are Mealy on mem_ready.
  always_comb begin
    w_next           = r_state;
    w_set_illegal    = 1'b0;
    pc_write         = 1'b0;
    pc_write_cond    = 1'b0;
    pc_write_cond_ne = 1'b0;
    iord             = 1'b0;
    memread          = 1'b0;
    memwrite         = 1'b0;
    irwrite          = 1'b0;
    memtoreg         = 1'b0;
    regdst           = 1'b0;
    regwrite         = 1'b0;
    alusrca          = 1'b0;
    alusrcb          = SRCB_REG;
    aluop            = ALUOP_ADD;
    pcsource         = PCSRC_ALU;
    instr_done       = 1'b0;

    case (r_state)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = SRCB_FOUR;
        if (w_timeout) begin
          w_next = S_HALT;
        end else if (mem_ready) begin
          irwrite  = 1'b1;
          pc_write = 1'b1;
          w_next   = S_DECODE;
        end
      end
      S_DECODE: begin
        alusrcb = SRCB_SEXT_SH;
        case (opcode)
          OP_RTYPE:      w_next = S_EXEC;
          OP_LW, OP_SW:  w_next = S_MEMADR;
          OP_BEQ, OP_BNE: w_next = S_BRANCH;
          OP_J:          w_next = S_JUMP;
          OP_ADDI:       w_next = S_ADDI_EX;
          default: begin
            w_next        = S_HALT;
            w_set_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_SEXT;
        w_next  = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
        if (w_timeout) begin
          w_next = S_HALT;
        end else if (mem_ready) begin
          w_next = S_MEMWB;
        end
      end
      S_MEMWB: begin
        regwrite   = 1'b1;
        memtoreg   = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
        if (w_timeout) begin
          w_next = S_HALT;
        end else if (mem_ready) begin
          instr_done = 1'b1;
          w_next     = S_FETCH;
        end
      end
      S_EXEC: begin
        alusrca = 1'b1;
        alusrcb = SRCB_REG;
        aluop   = ALUOP_FUNCT;
        w_next  = S_RWB;
      end
      S_RWB: begin
        regwrite   = 1'b1;
        regdst     = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        alusrca          = 1'b1;
        alusrcb          = SRCB_REG;
        aluop            = ALUOP_SUB;
        pcsource         = PCSRC_ALUOUT;
        pc_write_cond    = (opcode == OP_BEQ);
        pc_write_cond_ne = (opcode == OP_BNE);
        instr_done       = 1'b1;
        w_next           = S_FETCH;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pcsource   = PCSRC_JUMP;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_ADDI_EX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_SEXT;
        w_next  = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_HALT: begin
        w_next = S_HALT;
      end
      default: begin
        w_next = S_HALT;
      end
    endcase
  end

  assign state      = r_state;
  assign illegal_op = r_illegal;
  assign bus_error  = r_bus_error;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed testbench for the multicycle MIPS control FSM.
module tb_mips_multicycle_ctrl;

  logic       clock;
  logic       Reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       pc_write_cond_ne;
  logic       iord;
  logic       memread;
  logic       memwrite;
  logic       irwrite;
  logic       memtoreg;
  logic       regdst;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [2:0] aluop;
  logic [1:0] pcsource;
  logic [3:0] state;
  logic       instr_done;
  logic       illegal_op;
  logic       bus_error;

  int total = 0;
  int bad   = 0;

  mips_multicycle_ctrl #(.MAX_WAIT(15), .WAIT_W(8)) dut (
    .clock            (clock),
    .Reset            (Reset),
    .opcode           (opcode),
    .mem_ready        (mem_ready),
    .pc_write         (pc_write),
    .pc_write_cond    (pc_write_cond),
    .pc_write_cond_ne (pc_write_cond_ne),
    .iord             (iord),
    .memread          (memread),
    .memwrite         (memwrite),
    .irwrite          (irwrite),
    .memtoreg         (memtoreg),
    .regdst           (regdst),
    .regwrite         (regwrite),
    .alusrca          (alusrca),
    .alusrcb          (alusrcb),
    .aluop            (aluop),
    .pcsource         (pcsource),
    .state            (state),
    .instr_done       (instr_done),
    .illegal_op       (illegal_op),
    .bus_error        (bus_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  wire [18:0] all_ctrl = {pc_write, pc_write_cond, pc_write_cond_ne, iord, memread,
                          memwrite, irwrite, memtoreg, regdst, regwrite, alusrca,
                          alusrcb, aluop, pcsource, instr_done};

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Short async reset pulse placed mid-cycle.
  task automatic do_reset();
    Reset = 1'b0;
    #2;
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    Reset     = 1'b0;
    mem_ready = 1'b0;
    opcode    = 6'h00;
    repeat (3) tick();
    total++; if (state !== 4'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
    total++; if (illegal_op !== 1'b0 || bus_error !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", illegal_op, bus_error); end
    total++; if (pc_write !== 1'b0 || irwrite !== 1'b0) begin bad++; $display("FAIL reset_fetch_nowrite got=%b%b exp=00", pc_write, irwrite); end
    total++; if (memread !== 1'b1 || alusrcb !== 2'b01 || iord !== 1'b0) begin bad++; $display("FAIL reset_fetch_ctrl got=%b%b%b exp=1010", memread, alusrcb, iord); end
    Reset = 1'b1;
  endtask

  task automatic test_rtype();
    logic [3:0] exp_st [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    do_reset();
    opcode    = 6'h00;
    mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (state !== exp_st[i]) begin bad++; $display("FAIL rtype_state[%0d] got=%0d exp=%0d", i, state, exp_st[i]); end
      total++; if (regwrite !== (i == 3) || regdst !== (i == 3)) begin bad++; $display("FAIL rtype_wb[%0d] got=%b%b exp=%b%b", i, regwrite, regdst, i == 3, i == 3); end
      total++; if (instr_done !== (i == 3)) begin bad++; $display("FAIL rtype_done[%0d] got=%b exp=%b", i, instr_done, i == 3); end
      if (i == 0) begin
        total++; if (pc_write !== 1'b1 || irwrite !== 1'b1) begin bad++; $display("FAIL rtype_fetch_write got=%b%b exp=11", pc_write, irwrite); end
      end
      if (i == 2) begin
        total++; if (aluop !== 3'b010 || alusrca !== 1'b1 || alusrcb !== 2'b00) begin bad++; $display("FAIL rtype_exec got=%b%b%b exp=010100", aluop, alusrca, alusrcb); end
      end
      tick();
    end
  endtask

  task automatic test_lw_wait();
    logic [3:0] exp_st [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
    logic       rdy    [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    opcode = 6'h23;
    for (int i = 0; i < 8; i++) begin
      mem_ready = rdy[i];
      #1;
      total++; if (state !== exp_st[i]) begin bad++; $display("FAIL lw_state[%0d] got=%0d exp=%0d", i, state, exp_st[i]); end
      if (exp_st[i] == 4'd3) begin
        total++; if (memread !== 1'b1 || iord !== 1'b1) begin bad++; $display("FAIL lw_memrd[%0d] got=%b%b exp=11", i, memread, iord); end
      end
      total++; if (regwrite !== (i == 6) || memtoreg !== (i == 6) || instr_done !== (i == 6)) begin bad++; $display("FAIL lw_wb[%0d] got=%b%b%b exp=%b", i, regwrite, memtoreg, instr_done, i == 6); end
      if (i == 6) begin
        total++; if (regdst !== 1'b0) begin bad++; $display("FAIL lw_regdst got=%b exp=0", regdst); end
      end
      tick();
    end
  endtask

  task automatic test_branch();
    logic [5:0] ops [2] = '{6'h05, 6'h04};
    for (int k = 0; k < 2; k++) begin
      do_reset();
      opcode    = ops[k];
      mem_ready = 1'b1;
      tick();
      tick();
      #1;
      total++; if (state !== 4'd8) begin bad++; $display("FAIL branch_state[%0d] got=%0d exp=8", k, state); end
      total++; if (pc_write_cond_ne !== (k == 0) || pc_write_cond !== (k == 1)) begin bad++; $display("FAIL branch_cond[%0d] got=ne%b eq%b exp=ne%b eq%b", k, pc_write_cond_ne, pc_write_cond, k == 0, k == 1); end
      total++; if (aluop !== 3'b001 || pcsource !== 2'b01 || instr_done !== 1'b1 || pc_write !== 1'b0) begin bad++; $display("FAIL branch_ctrl[%0d] got=%b %b %b %b exp=001 01 1 0", k, aluop, pcsource, instr_done, pc_write); end
      tick();
      #1;
      total++; if (state !== 4'd0) begin bad++; $display("FAIL branch_ret[%0d] got=%0d exp=0", k, state); end
    end
  endtask

  task automatic test_latency();
    logic [5:0] ops    [7] = '{6'h00, 6'h2B, 6'h08, 6'h04, 6'h05, 6'h02, 6'h23};
    int         cycles [7] = '{4, 4, 4, 3, 3, 3, 5};
    logic [3:0] last   [7] = '{4'd7, 4'd5, 4'd11, 4'd8, 4'd8, 4'd9, 4'd4};
    int         seen;
    for (int k = 0; k < 7; k++) begin
      do_reset();
      opcode    = ops[k];
      mem_ready = 1'b1;
      seen      = 0;
      for (int c = 1; c <= 10; c++) begin
        #1;
        if (instr_done === 1'b1) begin
          seen = c;
          total++; if (state !== last[k]) begin bad++; $display("FAIL lat_last_state op=%0h got=%0d exp=%0d", ops[k], state, last[k]); end
          if (ops[k] == 6'h02) begin
            total++; if (pc_write !== 1'b1 || pcsource !== 2'b10) begin bad++; $display("FAIL jump_ctrl got=%b %b exp=1 10", pc_write, pcsource); end
          end
          if (ops[k] == 6'h2B) begin
            total++; if (memwrite !== 1'b1 || iord !== 1'b1) begin bad++; $display("FAIL sw_ctrl got=%b%b exp=11", memwrite, iord); end
          end
          if (ops[k] == 6'h08) begin
            total++; if (regwrite !== 1'b1 || regdst !== 1'b0 || memtoreg !== 1'b0) begin bad++; $display("FAIL addi_wb got=%b%b%b exp=100", regwrite, regdst, memtoreg); end
          end
          tick();
          break;
        end
        tick();
      end
      total++; if (seen != cycles[k]) begin bad++; $display("FAIL lat_cycles op=%0h got=%0d exp=%0d", ops[k], seen, cycles[k]); end
      #1;
      total++; if (state !== 4'd0) begin bad++; $display("FAIL lat_ret op=%0h got=%0d exp=0", ops[k], state); end
    end
  endtask

  task automatic test_illegal();
    do_reset();
    opcode    = 6'h3F;
    mem_ready = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 20; i++) begin
      #1;
      total++; if (state !== 4'd12 || illegal_op !== 1'b1 || all_ctrl !== 19'd0) begin bad++; $display("FAIL illegal_halt[%0d] got=st%0d ill%b ctrl%0h exp=st12 ill1 ctrl0", i, state, illegal_op, all_ctrl); end
      tick();
    end
    total++; if (bus_error !== 1'b0) begin bad++; $display("FAIL illegal_buserr got=%b exp=0", bus_error); end
    do_reset();
    #1;
    total++; if (illegal_op !== 1'b0 || state !== 4'd0) begin bad++; $display("FAIL illegal_clear got=ill%b st%0d exp=ill0 st0", illegal_op, state); end
    opcode = 6'h00;
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    opcode    = 6'h00;
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      #1;
      total++; if (state !== 4'd0 || pc_write !== 1'b0 || irwrite !== 1'b0 || bus_error !== 1'b0) begin bad++; $display("FAIL tmo_wait[%0d] got=st%0d pcw%b irw%b be%b exp=st0 pcw0 irw0 be0", i, state, pc_write, irwrite, bus_error); end
      tick();
    end
    #1;
    total++; if (state !== 4'd12 || bus_error !== 1'b1) begin bad++; $display("FAIL tmo_halt got=st%0d be%b exp=st12 be1", state, bus_error); end
    tick();
    // Ready on the very cycle the count reaches the limit is a success.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      mem_ready = (i == 14);
      #1;
      if (i == 14) begin
        total++; if (pc_write !== 1'b1 || irwrite !== 1'b1) begin bad++; $display("FAIL tmo_ready_wins got=%b%b exp=11", pc_write, irwrite); end
      end
      tick();
    end
    #1;
    total++; if (state !== 4'd1 || bus_error !== 1'b0) begin bad++; $display("FAIL tmo_edge got=st%0d be%b exp=st1 be0", state, bus_error); end
    tick();
  endtask

  task automatic test_reset_memwr();
    do_reset();
    opcode    = 6'h2B;
    mem_ready = 1'b1;
    tick();
    tick();
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (state !== 4'd5 || memwrite !== 1'b1 || instr_done !== 1'b0) begin bad++; $display("FAIL memwr_wait[%0d] got=st%0d mw%b done%b exp=st5 mw1 done0", i, state, memwrite, instr_done); end
      tick();
    end
    #2;
    Reset = 1'b0;
    #1;
    total++; if (state !== 4'd0 || memwrite !== 1'b0 || instr_done !== 1'b0) begin bad++; $display("FAIL memwr_async_reset got=st%0d mw%b done%b exp=st0 mw0 done0", state, memwrite, instr_done); end
    tick();
    Reset = 1'b1;
    #1;
    total++; if (state !== 4'd0 || bus_error !== 1'b0) begin bad++; $display("FAIL memwr_after got=st%0d be%b exp=st0 be0", state, bus_error); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_branch();
    test_latency();
    test_illegal();
    test_timeout();
    test_reset_memwr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
